// File: rtl/tube_pkg.sv
// Shared definitions for the eight-digit seven-segment tube driver: register offsets,
// FSM encoding, hex segment table and the leading-zero mask helper.
package tube_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } tube_state_e;

    localparam logic [1:0] TUBE_REG_DIGITS_LO = 2'b00;
    localparam logic [1:0] TUBE_REG_DIGITS_HI = 2'b01;
    localparam logic [1:0] TUBE_REG_BLANK     = 2'b10;
    localparam logic [1:0] TUBE_REG_DOT       = 2'b11;

    // Active-high {g,f,e,d,c,b,a} codes for 0-9, A, b, C, d, E, F
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bit i set when nibbles i..7 are all zero; digit 0 is never flagged
    function automatic logic [7:0] leading_zero_mask(input logic [31:0] nibbles);
        logic [7:0] mask;
        logic       any_set;
        mask    = 8'h00;
        any_set = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            any_set = any_set | (|nibbles[4*i +: 4]);
            mask[i] = ~any_set;
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_to_seven_segment.sv
// Pure combinational hex nibble to active-high seven-segment decoder.
module hex_to_seven_segment
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_HEX[nibble];

endmodule

// File: rtl/tube_display_driver.sv
// Eight-digit multiplexed tube driver with register-mapped digits, blank and dot masks.
// Optional build macro TUBE_LEADING_ZERO_SUPPRESS_EN darkens leading zero digits.
module tube_display_driver
    import tube_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iDoTubeWrite,
    input  logic [1:0]  iAddressLow,
    input  logic [15:0] iWriteData,
    output logic [7:0]  oDigitSelect,
    output logic [7:0]  oSegments
);

    localparam int             CW        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0]  SLOT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0]  BLANK_END = CW'(BLANK_CYCLES);

    logic [31:0]   nibbles_r;
    logic [7:0]    blank_mask_r;
    logic [7:0]    dot_mask_r;
    logic [CW-1:0] slot_count_r;
    logic [2:0]    digit_index_r;
    tube_state_e   state_r;
    logic [7:0]    digit_select_r;
    logic [7:0]    segments_r;

    logic [CW-1:0] slot_next_s;
    logic [2:0]    index_next_s;
    tube_state_e   state_next_s;
    logic [3:0]    nibble_sel_s;
    logic [6:0]    hex_seg_s;
    logic [7:0]    suppress_s;
    logic          digit_off_s;
    logic [7:0]    select_next_s;
    logic [7:0]    segments_next_s;

    // Slot counter, digit index and BLANK/SHOW sequencing for the coming cycle
    always_comb begin
        slot_next_s  = slot_count_r + CW'(1);
        index_next_s = digit_index_r;
        state_next_s = state_r;
        if (slot_count_r == SLOT_LAST) begin
            slot_next_s  = '0;
            index_next_s = digit_index_r + 3'd1;
        end else begin
            slot_next_s  = slot_count_r + CW'(1);
            index_next_s = digit_index_r;
        end
        case (state_r)
            ST_BLANK: begin
                if (slot_next_s >= BLANK_END) begin
                    state_next_s = ST_SHOW;
                end else begin
                    state_next_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (slot_count_r == SLOT_LAST) begin
                    state_next_s = ST_BLANK;
                end else begin
                    state_next_s = ST_SHOW;
                end
            end
            default: state_next_s = ST_BLANK;
        endcase
    end

    assign nibble_sel_s = nibbles_r[{index_next_s, 2'b00} +: 4];

    hex_to_seven_segment u_hex (
        .nibble   (nibble_sel_s),
        .segments (hex_seg_s)
    );

`ifdef TUBE_LEADING_ZERO_SUPPRESS_EN
    assign suppress_s = leading_zero_mask(nibbles_r);
`else
    assign suppress_s = 8'h00;
`endif

    // Output pattern for the digit the counter is about to present
    always_comb begin
        digit_off_s     = blank_mask_r[index_next_s] | suppress_s[index_next_s];
        select_next_s   = 8'hFF;
        segments_next_s = 8'hFF;
        if (state_next_s == ST_SHOW) begin
            select_next_s = ~(8'h01 << index_next_s);
            if (digit_off_s) begin
                segments_next_s = 8'hFF;
            end else begin
                segments_next_s = ~{dot_mask_r[index_next_s], hex_seg_s};
            end
        end else begin
            select_next_s   = 8'hFF;
            segments_next_s = 8'hFF;
        end
    end

    // Register file writes, FSM state and registered tube outputs
    always_ff @(posedge iClock) begin
        if (iReset) begin
            nibbles_r      <= 32'h0000_0000;
            blank_mask_r   <= 8'hFF;
            dot_mask_r     <= 8'h00;
            slot_count_r   <= '0;
            digit_index_r  <= 3'd0;
            state_r        <= ST_BLANK;
            digit_select_r <= 8'hFF;
            segments_r     <= 8'hFF;
        end else begin
            if (iDoTubeWrite) begin
                case (iAddressLow)
                    TUBE_REG_DIGITS_LO: nibbles_r[15:0]  <= iWriteData;
                    TUBE_REG_DIGITS_HI: nibbles_r[31:16] <= iWriteData;
                    TUBE_REG_BLANK:     blank_mask_r     <= iWriteData[7:0];
                    TUBE_REG_DOT:       dot_mask_r       <= iWriteData[7:0];
                    default:            nibbles_r        <= nibbles_r;
                endcase
            end
            slot_count_r   <= slot_next_s;
            digit_index_r  <= index_next_s;
            state_r        <= state_next_s;
            digit_select_r <= select_next_s;
            segments_r     <= segments_next_s;
        end
    end

    assign oDigitSelect = digit_select_r;
    assign oSegments    = segments_r;

endmodule

// File: tb/tb_tube_display_driver.sv
// Directed bench for tube_display_driver with short slots (8 clocks, 2 blank).
module tb_tube_display_driver;

    logic        iClock;
    logic        iReset;
    logic        iDoTubeWrite;
    logic [1:0]  iAddressLow;
    logic [15:0] iWriteData;
    logic [7:0]  oDigitSelect;
    logic [7:0]  oSegments;

    int vectors;
    int miscompares;

    tube_display_driver #(
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2)
    ) dut (
        .iClock       (iClock),
        .iReset       (iReset),
        .iDoTubeWrite (iDoTubeWrite),
        .iAddressLow  (iAddressLow),
        .iWriteData   (iWriteData),
        .oDigitSelect (oDigitSelect),
        .oSegments    (oSegments)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [15:0] data);
        iDoTubeWrite = 1'b1;
        iAddressLow  = addr;
        iWriteData   = data;
        tick();
        iDoTubeWrite = 1'b0;
    endtask

    // Advance at least one clock until the anode pattern appears (bounded)
    task automatic wait_for(input logic [7:0] target, input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (oDigitSelect !== target && n < 80);
        check(tag, oDigitSelect, target);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp [8]);
        int n;
        logic [7:0] anode;
        for (int d = 0; d < 8; d++) begin
            anode = ~(8'h01 << d);
            wait_for(anode, {tag, " anode"}, n);
            check($sformatf("%s seg%0d", tag, d), oSegments, exp[d]);
        end
    endtask

    logic [7:0] exp_dots [8];
    logic [7:0] exp_lz   [8];
    logic [7:0] exp_zero [8];
    int n;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        iReset       = 1'b1;
        iDoTubeWrite = 1'b0;
        iAddressLow  = 2'b00;
        iWriteData   = 16'h0000;
        exp_dots = '{8'h19, 8'hB0, 8'hA4, 8'hF9, 8'hA1, 8'hC6, 8'h83, 8'h08};

        // 1. reset and first SHOW at cycle 2 with everything blanked
        tick(); tick(); tick();
        check("reset anode", oDigitSelect, 8'hFF);
        check("reset seg", oSegments, 8'hFF);
        iReset = 1'b0;
        tick();
        check("cycle1 anode", oDigitSelect, 8'hFF);
        tick();
        check("first show anode", oDigitSelect, 8'hFE);
        check("first show seg", oSegments, 8'hFF);

        // 2. digits 0xABCD1234 unblanked
        wr(2'b10, 16'h0000);
        wr(2'b00, 16'h1234);
        wr(2'b01, 16'hABCD);
        wait_for(8'h7F, "digit7 anode", n);
        check("digit7 A", oSegments, 8'h88);
        wait_for(8'hFE, "digit0 anode", n);
        check("digit0 4", oSegments, 8'h99);
        wait_for(8'hFD, "digit1 anode", n);
        check("slot spacing", 8'(n), 8'd8);

        // 3. decimal points on digits 0 and 7
        wr(2'b11, 16'h0081);
        check_frame("dots", exp_dots);

        // 4. mid-slot write to digit 3, then write on the wrap edge to digit 4
        wait_for(8'hF7, "digit3 anode", n);
        check("digit3 before", oSegments, 8'hF9);
        wr(2'b00, 16'h0234);
        check("digit3 same edge", oSegments, 8'hF9);
        check("digit3 anode held", oDigitSelect, 8'hF7);
        tick();
        check("digit3 updated", oSegments, 8'hC0);
        tick(); tick(); tick();
        check("digit3 last cycle", oDigitSelect, 8'hF7);
        wr(2'b01, 16'hABCE);
        check("wrap blank anode", oDigitSelect, 8'hFF);
        wait_for(8'hEF, "digit4 anode", n);
        check("digit4 new E", oSegments, 8'h86);

        // 5. reset in the middle of digit 5
        wait_for(8'hDF, "digit5 anode", n);
        check("digit5 C", oSegments, 8'hC6);
        tick();
        iReset = 1'b1;
        tick();
        check("midreset anode", oDigitSelect, 8'hFF);
        check("midreset seg", oSegments, 8'hFF);
        iReset = 1'b0;
        tick();
        check("post reset blank", oDigitSelect, 8'hFF);
        tick();
        check("post reset index0", oDigitSelect, 8'hFE);
        check("post reset masked", oSegments, 8'hFF);
        wr(2'b10, 16'h0000);
        tick();
        check("digit0 cleared", oSegments, 8'hC0);
        wait_for(8'hDF, "digit5 anode2", n);
        check("digit5 cleared", oSegments, 8'hC0);

        // 6. leading zero handling, dots on every digit
        wr(2'b00, 16'h0040);
        wr(2'b01, 16'h0000);
        wr(2'b11, 16'h00FF);
`ifdef TUBE_LEADING_ZERO_SUPPRESS_EN
        exp_lz   = '{8'h40, 8'h19, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_zero = '{8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_lz   = '{8'h40, 8'h19, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
        exp_zero = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40};
`endif
        check_frame("lz40", exp_lz);
        wr(2'b00, 16'h0000);
        check_frame("lz0", exp_zero);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
